opb_register_ppc2simulink: RTL
==============================

OPB_REGISTER_PPC2SIMULINK -- requirements
Module: opb_register_ppc2simulink

Interface
REQ-001 The block SHALL have parameter C_BASEADDR, default 32'h00000000, meaning the first byte address decoded.
REQ-002 The block SHALL have parameter C_HIGHADDR, default 32'h000000FF, meaning the last byte address decoded.
REQ-003 The block SHALL have parameter C_OPB_AWIDTH, default 32, meaning the OPB address width.
REQ-004 The block SHALL have parameter C_OPB_DWIDTH, default 32, meaning the OPB data width.
REQ-005 The block SHALL have parameter C_FAMILY, default "virtex5", meaning the target family (informational only).
REQ-006 The block SHALL have parameter C_INIT_VALUE, default 32'h00000000, meaning the reset value of the data register.
REQ-007 Ports SHALL be as follows; OPB buses use [0:31] with bit 0 as MSB:
OPB_Clk  in  1  sole clock; every register updates on its rising edge
OPB_Rst  in  1  reset; synchronous and active-high
OPB_ABus  in  32  address
OPB_BE  in  4  byte enables; BE[0] covers DBus[0:7]
OPB_DBus  in  32  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  32  read data
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  constant 0
Sl_retry  out  1  constant 0
Sl_toutSup  out  1  constant 0
user_data_out  out  [31:0]  data register; user_data_out[31] = DBus[0]
user_data_strobe  out  1  one-cycle pulse on each data-register update

Function
REQ-008 A hit SHALL be OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
REQ-009 The FSM SHALL have exactly three states, IDLE, ACK and TURN, with these transitions:
- IDLE→ACK on a hit; otherwise stay in IDLE.
- ACK→TURN unconditionally.
- TURN→IDLE unconditionally.
REQ-010 Sl_xferAck SHALL be 1 only in ACK, giving one cycle of latency from a sampled hit to acknowledge and a minimum of 3 cycles per transfer.
REQ-011 Address, BE, RNW and DBus SHALL be captured in the cycle the hit is sampled, and that capture SHALL be used in ACK.
REQ-012 The register map SHALL be, by offset from C_BASEADDR:
- 0x0: DATA, read/write.
- 0x4: WCOUNT, read-only, 16 bits, read data zero-extended into the LSBs.
- Any other in-range offset: acknowledged, reads return 0, writes are ignored.
REQ-013 Sl_DBus SHALL carry read data only while Sl_xferAck=1 with RNW=1, and SHALL be all-zero otherwise, as required for the OPB OR-bus.
REQ-014 A write to DATA SHALL update only the bytes whose BE bit is 1.
REQ-015 The new value SHALL appear on user_data_out in the cycle after ACK.
REQ-016 user_data_strobe SHALL be 1 in that same cycle, and only when at least one BE bit is 1.
REQ-017 A DATA write with BE=0000 SHALL be acknowledged, SHALL leave DATA unchanged, and SHALL produce neither a strobe nor a count.
REQ-018 WCOUNT SHALL increment by 1 on each DATA write that produces a strobe, and SHALL wrap from 0xFFFF to 0x0000.
REQ-019 A read of DATA SHALL return the register value as it stands before any same-cycle effects.
REQ-020 Writes to WCOUNT SHALL be acknowledged and ignored.
REQ-021 A hit arriving in ACK or TURN SHALL NOT be sampled; it SHALL be re-evaluated in IDLE.
REQ-022 If OPB_select drops while the FSM is in ACK, the FSM SHALL still complete ACK→TURN→IDLE.

Reset
REQ-023 While OPB_Rst=1 on a clock edge, the block SHALL force:
- FSM = IDLE;
- DATA = C_INIT_VALUE;
- WCOUNT = 0;
- Sl_xferAck = 0;
- Sl_DBus = 0;
- user_data_strobe = 0.
REQ-024 A reset asserted in ACK SHALL abort the transfer, with no ack and no register update on the following edge.
REQ-025 After reset, user_data_out SHALL equal C_INIT_VALUE.

Structure
REQ-026 The FSM state encoding and the register offsets (0x0, 0x4) SHALL live in a shared package, opb_reg_pkg.
REQ-027 The block SHALL be implemented as one sub-module, opb_slave_fsm, providing hit detection, capture and the xferAck/TURN sequencing; the top level SHALL hold DATA, WCOUNT and the read mux.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Reset, then idle for 5 cycles → user_data_out=C_INIT_VALUE, Sl_DBus=0, Sl_xferAck=0, user_data_strobe=0.
- Write 0xDEADBEEF to offset 0x0 with BE=1111 → Sl_xferAck one cycle after select; next cycle user_data_out=32'hDEADBEEF, strobe=1 for 1 cycle, WCOUNT=1.
- Write 0x11223344 with BE=0100, starting from DATA=0xDEADBEEF → user_data_out=32'hDE22BEEF; a read of 0x0 returns 0xDE22BEEF on Sl_DBus during ack only.
- Write with BE=0000; write to offset 0x8; read of offset 0x8 → all acknowledged; DATA, WCOUNT and strobe unchanged; the read returns 0.
- Preload 0xFFFF DATA writes, then one more → a WCOUNT read returns 0x00000000.
- Assert OPB_Rst in the ACK cycle of a write of 0x12345678 → no xferAck, user_data_out=C_INIT_VALUE, FSM in IDLE, the next transfer completes normally.

Source files
------------

// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB register slave.
//   - FSM state encoding (IDLE / ACK / TURN)
//   - register offsets relative to C_BASEADDR
//   - capture record handed from the slave FSM to the register block
//   - byte-lane merge helper
package opb_reg_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_TURN = 2'd2;

  localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_WCOUNT = 32'h0000_0004;

  localparam int WCOUNT_W = 16;

  // Everything needed to finish a transfer in ACK. Bit order is little-endian
  // ([31:0]); be[3] is OPB_BE[0] and covers data[31:24].
  typedef struct packed {
    logic [31:0] offset;
    logic [3:0]  be;
    logic        rnw;
    logic [31:0] data;
  } opb_xfer_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_slave_fsm.sv
// OPB slave handshake: address hit detection, request capture and the
// IDLE -> ACK -> TURN sequencing that yields one acknowledge per transfer.
//
// Ports
//   clk_i      OPB clock
//   rst_i      synchronous active-high reset
//   abus_i     OPB address, bit 0 = MSB
//   be_i       OPB byte enables, be_i[0] covers dbus_i[0:7]
//   dbus_i     OPB write data, bit 0 = MSB
//   rnw_i      1 = read, 0 = write
//   select_i   transfer request
//   ack_o      high for the single ACK cycle
//   xfer_o     request captured when the hit was sampled
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a hit; the only state that samples the bus
// ACK     | acknowledge cycle, captured request is acted on
// TURN    | bus turnaround, requests are ignored
module opb_slave_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [0:31] abus_i,
  input  logic [0:3]  be_i,
  input  logic [0:31] dbus_i,
  input  logic        rnw_i,
  input  logic        select_i,
  output logic        ack_o,
  output opb_xfer_t   xfer_o
);

  localparam logic [31:0] SPAN = C_HIGHADDR - C_BASEADDR;

  logic [1:0]  state_q, state_d;
  opb_xfer_t   xfer_q, xfer_d;
  logic        borrow;
  logic [31:0] offset;
  logic        hit;

  // A borrow out of the subtraction means the address is below the window;
  // the offset is kept so the register block never has to subtract again.
  assign {borrow, offset} = {1'b0, abus_i} - {1'b0, C_BASEADDR};
  assign hit = select_i & ~borrow & (offset <= SPAN);

  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d       = ST_ACK;
          xfer_d.offset = offset;
          xfer_d.be     = be_i;
          xfer_d.rnw    = rnw_i;
          xfer_d.data   = dbus_i;
        end
      end
      ST_ACK:  state_d = ST_TURN;
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
    end
  end

  assign ack_o  = (state_q == ST_ACK);
  assign xfer_o = xfer_q;

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave exposing one 32-bit read/write DATA register to user logic,
// plus a read-only 16-bit count of DATA writes (WCOUNT).
//
// Ports
//   OPB_Clk, OPB_Rst        clock and synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW    OPB request, bit 0 = MSB
//   OPB_select              transfer request
//   OPB_seqAddr             unused
//   Sl_DBus                 read data, zero outside a read acknowledge
//   Sl_xferAck              transfer acknowledge
//   Sl_errAck/retry/toutSup tied low
//   user_data_out           DATA register, user_data_out[31] = DBus[0]
//   user_data_strobe        one-cycle pulse when DATA is written
module opb_register_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5",
  parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [31:0]               user_data_out,
  output logic                      user_data_strobe
);

  logic                fsm_ack;
  opb_xfer_t           xfer;
  logic                ack_live;
  logic                data_wr;
  logic [31:0]         rd_data;

  logic [31:0]         data_q, data_d;
  logic [WCOUNT_W-1:0] wcount_q, wcount_d;
  logic                strobe_q, strobe_d;

  logic                unused_seq;
  assign unused_seq = OPB_seqAddr;

  opb_slave_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_fsm (
    .clk_i    (OPB_Clk),
    .rst_i    (OPB_Rst),
    .abus_i   (OPB_ABus),
    .be_i     (OPB_BE),
    .dbus_i   (OPB_DBus),
    .rnw_i    (OPB_RNW),
    .select_i (OPB_select),
    .ack_o    (fsm_ack),
    .xfer_o   (xfer)
  );

  // Reset arriving during ACK aborts the transfer, so the acknowledge and the
  // read data are suppressed in that cycle as well.
  assign ack_live = fsm_ack & ~OPB_Rst;

  assign data_wr = fsm_ack & ~xfer.rnw & (xfer.offset == OFF_DATA) & (|xfer.be);

  always_comb begin
    data_d   = data_q;
    wcount_d = wcount_q;
    strobe_d = data_wr;
    if (data_wr) begin
      data_d   = merge_bytes(data_q, xfer.data, xfer.be);
      wcount_d = wcount_q + 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    if (xfer.offset == OFF_DATA)        rd_data = data_q;
    else if (xfer.offset == OFF_WCOUNT) rd_data = {{(32-WCOUNT_W){1'b0}}, wcount_q};
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      data_q   <= C_INIT_VALUE;
      wcount_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      wcount_q <= wcount_d;
      strobe_q <= strobe_d;
    end
  end

  // OR-bus: drive zeros unless this slave is acknowledging a read.
  assign Sl_DBus          = (ack_live & xfer.rnw) ? rd_data : '0;
  assign Sl_xferAck       = ack_live;
  assign Sl_errAck        = 1'b0;
  assign Sl_retry         = 1'b0;
  assign Sl_toutSup       = 1'b0;
  assign user_data_out    = data_q;
  assign user_data_strobe = strobe_q;

endmodule
